// File: rtl/framebuf_stream_reader_pkg.sv
// Shared types and helpers for the frame-buffer stream reader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: scan FSM state encoding and a counter-width helper that never returns 0.
package framebuf_stream_reader_pkg;

   // Defaults for a QQVGA RGB565 frame buffer.
   localparam int DEF_IMG_WIDTH  = 160;
   localparam int DEF_IMG_HEIGHT = 120;
   localparam int DEF_PIX_W      = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Width of a counter holding 0..n-1; keeps at least one bit for n <= 2.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/framebuf_stream_reader_pix_skid_fifo.sv
// Two-entry register FIFO carrying a pixel plus its x/y/eol/eof tags; head is always entry 0.
// Latency: a push is visible at the head one cycle later (no same-cycle bypass).
// Backpressure: no internal guard; the producer must never push while full without a pop.
// Ports: clk, rst (async, active-high); push + push_* payload; pop; valid/data/x/y/eol/eof head; count.
module pix_skid_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int XW         = 8,
   parameter int YW         = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic [XW-1:0]         push_x,
   input  logic [YW-1:0]         push_y,
   input  logic                  push_eol,
   input  logic                  push_eof,
   input  logic                  pop,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data,
   output logic [XW-1:0]         x,
   output logic [YW-1:0]         y,
   output logic                  eol,
   output logic                  eof,
   output logic [1:0]            count
);

   localparam int EW = DATA_WIDTH + XW + YW + 2;

   logic [EW-1:0] ent0;
   logic [EW-1:0] ent1;
   logic [EW-1:0] din;

   assign din = {push_data, push_x, push_y, push_eol, push_eof};
   assign {data, x, y, eol, eof} = ent0;
   assign valid = (count != 2'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent0  <= '0;
         ent1  <= '0;
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) ent0 <= din;
               else               ent1 <= din;
               count <= count + 2'd1;
            end
            2'b01: begin
               ent0  <= ent1;
               count <= count - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged; the new beat lands behind whatever remains.
               if (count == 2'd1) begin
                  ent0 <= din;
               end else begin
                  ent0 <= ent1;
                  ent1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/framebuf_stream_reader.sv
// Scans a full frame out of a 1-cycle registered-read RAM in raster order as a valid/ready pixel stream.
// Latency: start at cycle 0, first address at cycle 1, first m_valid at cycle 3; one beat/cycle when m_ready=1.
// Backpressure: reads are credit-limited to the 2-entry FIFO, so m_ready low stalls issue with no data loss.
// Ports: clk, rst (async, active-high); start/busy/done control; ram_addr/ram_dout RAM read port;
//        m_valid/m_ready handshake with m_data, m_x, m_y, m_eol, m_eof.
module framebuf_stream_reader
   import framebuf_stream_reader_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_PIX_W,
   parameter int ADDR_WIDTH = 15,
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int BASE_ADDR  = 0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   output logic                            busy,
   output logic                            done,
   output logic [ADDR_WIDTH-1:0]           ram_addr,
   input  logic [DATA_WIDTH-1:0]           ram_dout,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [DATA_WIDTH-1:0]           m_data,
   output logic [cnt_w(IMG_WIDTH)-1:0]     m_x,
   output logic [cnt_w(IMG_HEIGHT)-1:0]    m_y,
   output logic                            m_eol,
   output logic                            m_eof
);

   localparam int XW = cnt_w(IMG_WIDTH);
   localparam int YW = cnt_w(IMG_HEIGHT);
   localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [XW-1:0]         X_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0]         Y_LAST = YW'(IMG_HEIGHT - 1);

   state_t          state;
   state_t          state_nxt;
   logic [XW-1:0]   x_cnt;
   logic [YW-1:0]   y_cnt;
   logic            last_pix;
   logic            start_acc;
   logic            issue;
   logic            inflight;
   logic            pop;
   logic [1:0]      fifo_count;
   logic [2:0]      occ;
   logic [XW-1:0]   tag_x;
   logic [YW-1:0]   tag_y;
   logic            tag_eol;
   logic            tag_eof;

   assign last_pix = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
   assign pop      = m_valid & m_ready;
   // Entries the FIFO is committed to: stored beats plus the read whose data arrives next cycle.
   assign occ      = {1'b0, fifo_count} + {2'b00, inflight};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start)             state_nxt = ST_RUN;
         ST_RUN:   if (issue && last_pix) state_nxt = ST_DRAIN;
         ST_DRAIN: if (pop && m_eof)      state_nxt = ST_IDLE;
         default:                         state_nxt = ST_IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      busy      = (state != ST_IDLE);
      start_acc = (state == ST_IDLE) && start;
      // A beat popped this cycle frees its slot in time for the read issued now.
      issue     = (state == ST_RUN) && (occ < (3'd2 + {2'b00, pop}));
   end

   // Raster counters, in-flight tag and done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_addr <= BASE;
         x_cnt    <= '0;
         y_cnt    <= '0;
         inflight <= 1'b0;
         tag_x    <= '0;
         tag_y    <= '0;
         tag_eol  <= 1'b0;
         tag_eof  <= 1'b0;
         done     <= 1'b0;
      end else begin
         done     <= (state == ST_DRAIN) && pop && m_eof;
         inflight <= issue;
         if (issue) begin
            tag_x   <= x_cnt;
            tag_y   <= y_cnt;
            tag_eol <= (x_cnt == X_LAST);
            tag_eof <= last_pix;
         end
         if (start_acc) begin
            ram_addr <= BASE;
            x_cnt    <= '0;
            y_cnt    <= '0;
         end else if (issue && !last_pix) begin
            // Raster order is contiguous in RAM, so the address is a plain increment.
            ram_addr <= ram_addr + 1'b1;
            if (x_cnt == X_LAST) begin
               x_cnt <= '0;
               y_cnt <= y_cnt + 1'b1;
            end else begin
               x_cnt <= x_cnt + 1'b1;
            end
         end
      end
   end

   // RAM data is registered one cycle after its address, so inflight marks it valid at ram_dout now.
   pix_skid_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .XW         (XW),
      .YW         (YW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data (ram_dout),
      .push_x    (tag_x),
      .push_y    (tag_y),
      .push_eol  (tag_eol),
      .push_eof  (tag_eof),
      .pop       (pop),
      .valid     (m_valid),
      .data      (m_data),
      .x         (m_x),
      .y         (m_y),
      .eol       (m_eol),
      .eof       (m_eof),
      .count     (fifo_count)
   );

endmodule
